hcsr04_echo_emulator: RTL and testbench



---
 rtl/hcsr04_echo_emulator.sv | 203 ++++++++++++++++++++
 tb/tb_hcsr04_echo_emulator.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_echo_emulator.sv
// hcsr04_echo_emulator
//   Responder model of an HC-SR04 ultrasonic sensor. A valid trig pulse from
//   the controller starts an emulated burst delay. An echo pulse follows, and
//   its width encodes the latched target distance (or a timeout when there is
//   no target).
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   trig         trigger from controller, asynchronous to clk
//   distance_cm  emulated target distance in cm (latched on trig acceptance)
//   target_valid 1 = target present, 0 = no reflection (latched on acceptance)
//   echo         registered echo pulse to controller
//   busy         registered, high whenever the FSM is not in IDLE
//   meas_count   completed echo pulses, wraps at 65535
//
// Optional build macro
//   ECHO_JITTER_EN : when defined, a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1,
//   seed 16'hACE1) steps once per accepted trig. Its low nibble is added to
//   in-range echo widths. Timeout widths are never jittered.

module hcsr04_echo_emulator #(
    parameter int MIN_TRIG_CYCLES = 1000,
    parameter int BURST_CYCLES    = 20000,
    parameter int CYCLES_PER_CM   = 5800,
    parameter int MIN_DIST_CM     = 2,
    parameter int MAX_DIST_CM     = 400,
    parameter int TIMEOUT_CYCLES  = 3800000,
    parameter int HOLDOFF_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [8:0]  distance_cm,
    input  logic        target_valid,
    output logic        echo,
    output logic        busy,
    output logic [15:0] meas_count
);

    localparam int SUB_W = ($clog2(CYCLES_PER_CM) < 1) ? 1 : $clog2(CYCLES_PER_CM);

    localparam logic [15:0]      MIN_TRIG     = 16'(MIN_TRIG_CYCLES);
    localparam logic [SUB_W-1:0] SUB_RELOAD   = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [8:0]       MIN_DIST     = 9'(MIN_DIST_CM);
    localparam logic [8:0]       MAX_DIST     = 9'(MAX_DIST_CM);
    localparam logic [21:0]      BURST_LOAD   = 22'(BURST_CYCLES - 1);
    localparam logic [21:0]      TIMEOUT_LOAD = 22'(TIMEOUT_CYCLES - 1);
    localparam logic [21:0]      HOLDOFF_LOAD = 22'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t           state;
    logic             trig_meta;
    logic             trig_sync;
    logic             trig_prev;
    logic [15:0]      trig_cnt;
    logic [21:0]      wait_cnt;     // burst delay, timeout echo width, holdoff
    logic [8:0]       cm_cnt;       // whole centimetres still to emit
    logic [SUB_W-1:0] sub_cnt;      // cycles left in the current centimetre
    logic             lat_timeout;
    logic             echo_done;

    logic [8:0] dist_eff;
    logic       out_of_range;

    assign dist_eff     = (distance_cm < MIN_DIST) ? MIN_DIST : distance_cm;
    assign out_of_range = !target_valid || (distance_cm > MAX_DIST);

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0]  jit_cnt;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
`endif

    // Echo ends on the cycle the active width counter(s) reach zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves echo_done unassigned (no latch).
        echo_done = 1'b0;
        if (lat_timeout) begin
            echo_done = (wait_cnt == 22'd0);
        end else begin
            echo_done = (cm_cnt == 9'd0) && (sub_cnt == '0);
`ifdef ECHO_JITTER_EN
            echo_done = echo_done && (jit_cnt == 4'd0);
`endif
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            trig_meta   <= 1'b0;
            trig_sync   <= 1'b0;
            trig_prev   <= 1'b0;
            trig_cnt    <= 16'd0;
            wait_cnt    <= 22'd0;
            cm_cnt      <= 9'd0;
            sub_cnt     <= '0;
            lat_timeout <= 1'b0;
            echo        <= 1'b0;
            busy        <= 1'b0;
            meas_count  <= 16'd0;
`ifdef ECHO_JITTER_EN
            lfsr        <= 16'hACE1;
            jit_cnt     <= 4'd0;
`endif
        end else begin
            trig_meta <= trig;
            trig_sync <= trig_meta;
            trig_prev <= trig_sync;

            case (state)
                IDLE: begin
                    if (trig_sync && !trig_prev) begin
                        // The rise cycle itself is the first counted high cycle.
                        trig_cnt <= 16'd1;
                        busy     <= 1'b1;
                        state    <= TRIG_HI;
                    end
                end

                TRIG_HI: begin
                    if (trig_sync) begin
                        if (trig_cnt != 16'hFFFF) begin
                            trig_cnt <= trig_cnt + 16'd1;
                        end
                    end else if (trig_cnt >= MIN_TRIG) begin
                        lat_timeout <= out_of_range;
                        cm_cnt      <= dist_eff - 9'd1;
                        sub_cnt     <= SUB_RELOAD;
                        wait_cnt    <= BURST_LOAD;
`ifdef ECHO_JITTER_EN
                        lfsr        <= lfsr_next;
                        jit_cnt     <= out_of_range ? 4'd0 : lfsr_next[3:0];
`endif
                        state       <= BURST;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                BURST: begin
                    if (wait_cnt == 22'd0) begin
                        echo     <= 1'b1;
                        wait_cnt <= TIMEOUT_LOAD;
                        state    <= ECHO;
                    end else begin
                        wait_cnt <= wait_cnt - 22'd1;
                    end
                end

                ECHO: begin
                    if (echo_done) begin
                        echo       <= 1'b0;
                        meas_count <= meas_count + 16'd1;
                        wait_cnt   <= HOLDOFF_LOAD;
                        state      <= HOLDOFF;
                    end else if (lat_timeout) begin
                        wait_cnt <= wait_cnt - 22'd1;
                    end else if (sub_cnt != '0) begin
                        sub_cnt <= sub_cnt - 1'b1;
                    end else if (cm_cnt != 9'd0) begin
                        cm_cnt  <= cm_cnt - 9'd1;
                        sub_cnt <= SUB_RELOAD;
                    end
`ifdef ECHO_JITTER_EN
                    else begin
                        // Distance width is finished; extra jitter cycles follow.
                        jit_cnt <= jit_cnt - 4'd1;
                    end
`endif
                end

                HOLDOFF: begin
                    if (wait_cnt == 22'd0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 22'd1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    echo  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// tb_hcsr04_echo_emulator
//   Self-checking bench for hcsr04_echo_emulator using scaled-down timing
//   parameters. It runs a table of directed trig/distance vectors, holdoff and
//   mid-echo reset sequences, then randomized trials checked against an
//   arithmetic width model. With ECHO_JITTER_EN defined, a reference LFSR
//   predicts the jitter.

module tb_hcsr04_echo_emulator;

    localparam int P_MIN_TRIG = 10;
    localparam int P_BURST    = 20;
    localparam int P_CPC      = 7;
    localparam int P_MIN_DIST = 2;
    localparam int P_MAX_DIST = 40;
    localparam int P_TIMEOUT  = 300;
    localparam int P_HOLDOFF  = 50;

    logic        clk;
    logic        rst;
    logic        trig;
    logic [8:0]  distance_cm;
    logic        target_valid;
    logic        echo;
    logic        busy;
    logic [15:0] meas_count;

    hcsr04_echo_emulator #(
        .MIN_TRIG_CYCLES(P_MIN_TRIG),
        .BURST_CYCLES   (P_BURST),
        .CYCLES_PER_CM  (P_CPC),
        .MIN_DIST_CM    (P_MIN_DIST),
        .MAX_DIST_CM    (P_MAX_DIST),
        .TIMEOUT_CYCLES (P_TIMEOUT),
        .HOLDOFF_CYCLES (P_HOLDOFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .distance_cm (distance_cm),
        .target_valid(target_valid),
        .echo        (echo),
        .busy        (busy),
        .meas_count  (meas_count)
    );

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int pulses     = 0;
    int last_rise  = 0;
    int last_width = 0;
    int model_meas = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Echo pulse monitor: samples just after each rising edge.
    initial begin
        logic in_pulse;
        in_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_pulse = 1'b0;
            end else if (echo && !in_pulse) begin
                in_pulse  = 1'b1;
                last_rise = cyc;
            end else if (!echo && in_pulse) begin
                in_pulse   = 1'b0;
                last_width = cyc - last_rise;
                pulses++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input longint actual,
                               input longint lo, input longint hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Reference echo width from the distance rules.
    function automatic int model_width(input int d, input bit tv);
        if (!tv || d > P_MAX_DIST) return P_TIMEOUT;
        if (d < P_MIN_DIST) return P_MIN_DIST * P_CPC;
        return d * P_CPC;
    endfunction

`ifdef ECHO_JITTER_EN
    logic [15:0] ref_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction
`endif

    // Called once per accepted trig; returns the width including any jitter.
    function automatic int add_jitter(input int w);
`ifdef ECHO_JITTER_EN
        ref_lfsr = lfsr_step(ref_lfsr);
        if (w != P_TIMEOUT) return w + int'(ref_lfsr[3:0]);
`endif
        return w;
    endfunction

    // Must be called at a negedge; returns at the negedge where trig falls.
    task automatic pulse_trig(input int w, output int fall_cyc);
        trig = 1'b1;
        repeat (w) @(negedge clk);
        trig = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic wait_pulse(input int p0, input int budget, input string tag);
        int n;
        n = 0;
        while (pulses == p0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " echo seen"}, longint'(pulses > p0), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Must be called at a negedge.
    task automatic run_trial(input int w, input int d, input bit tv, input bit exp_echo,
                             input int exp_w_in, input bit scramble, input string tag);
        int p0;
        int fall_cyc;
        int exp_w;
        p0 = pulses;
        distance_cm  = 9'(d);
        target_valid = tv;
        pulse_trig(w, fall_cyc);
        if (!exp_echo) begin
            check({tag, " busy at fall"}, busy, 1);
            repeat (3) @(negedge clk);
            check({tag, " busy dropped"}, busy, 0);
            repeat (P_BURST + 20) @(negedge clk);
            check({tag, " no echo"}, pulses - p0, 0);
            check({tag, " meas kept"}, meas_count, model_meas);
        end else begin
            exp_w = add_jitter(exp_w_in);
            if (scramble) begin
                // Inputs are latched by now; changing them must not matter.
                repeat (4) @(negedge clk);
                distance_cm  = 9'($urandom_range(0, 511));
                target_valid = 1'($urandom_range(0, 1));
            end
            wait_pulse(p0, P_BURST + P_TIMEOUT + 100, tag);
            check_range({tag, " rise delay"}, last_rise - fall_cyc, P_BURST + 1, P_BURST + 3);
            check({tag, " width"}, last_width, exp_w);
`ifdef ECHO_JITTER_EN
            if (exp_w_in != P_TIMEOUT)
                check_range({tag, " jitter range"}, last_width, exp_w_in, exp_w_in + 15);
`endif
            model_meas++;
            check({tag, " meas"}, meas_count, model_meas);
            wait_idle(P_HOLDOFF + 10, tag);
        end
    endtask

    typedef struct {
        int    w;
        int    d;
        bit    tv;
        bit    exp_echo;
        int    exp_w;
        string name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int p0;
        int p1;
        int fall_cyc;
        int dummy;
        int exp_w;
        int n;

        vecs[0]  = '{10, 10, 1'b1, 1'b1, 70,  "v_nominal"};
        vecs[1]  = '{9,  10, 1'b1, 1'b0, 0,   "v_short_trig"};
        vecs[2]  = '{10, 5,  1'b0, 1'b1, 300, "v_no_target"};
        vecs[3]  = '{10, 45, 1'b1, 1'b1, 300, "v_over_range"};
        vecs[4]  = '{10, 0,  1'b1, 1'b1, 14,  "v_zero_dist"};
        vecs[5]  = '{10, 1,  1'b1, 1'b1, 14,  "v_below_min"};
        vecs[6]  = '{10, 2,  1'b1, 1'b1, 14,  "v_at_min"};
        vecs[7]  = '{10, 40, 1'b1, 1'b1, 280, "v_at_max"};
        vecs[8]  = '{10, 41, 1'b1, 1'b1, 300, "v_max_plus1"};
        vecs[9]  = '{11, 3,  1'b1, 1'b1, 21,  "v_dist3"};
        vecs[10] = '{30, 39, 1'b1, 1'b1, 273, "v_long_trig"};

        rst          = 1'b1;
        trig         = 1'b0;
        distance_cm  = 9'd0;
        target_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset echo", echo, 0);
        check("reset busy", busy, 0);
        check("reset meas", meas_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_trial(vecs[i].w, vecs[i].d, vecs[i].tv, vecs[i].exp_echo,
                      vecs[i].exp_w, 1'b0, vecs[i].name);

        // Trig during ECHO and during HOLDOFF is ignored; one just past HOLDOFF is taken.
        p0 = pulses;
        distance_cm  = 9'd10;
        target_valid = 1'b1;
        pulse_trig(10, fall_cyc);
        exp_w = add_jitter(70);
        n = 0;
        while (!echo && n < P_BURST + 20) begin
            @(negedge clk);
            n++;
        end
        check("hold echo up", echo, 1);
        pulse_trig(10, dummy);
        wait_pulse(p0, P_TIMEOUT, "hold");
        check("hold width", last_width, exp_w);
        model_meas++;
        check("hold meas", meas_count, model_meas);
        check("hold busy in holdoff", busy, 1);
        repeat (25) @(negedge clk);
        p1 = pulses;
        pulse_trig(10, dummy);
        repeat (P_HOLDOFF + 1 - 35) @(negedge clk);
        check("holdoff trig ignored", pulses - p1, 0);
        check("holdoff meas kept", meas_count, model_meas);
        check("holdoff over busy", busy, 0);
        run_trial(10, 10, 1'b1, 1'b1, 70, 1'b0, "post_holdoff");

        // Reset in the middle of an echo pulse.
        distance_cm  = 9'd20;
        target_valid = 1'b1;
        pulse_trig(10, dummy);
        n = 0;
        while (!echo && n < P_BURST + 20) begin
            @(negedge clk);
            n++;
        end
        check("rst pre echo", echo, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst echo drop", echo, 0);
        check("rst busy", busy, 0);
        check("rst meas", meas_count, 0);
        model_meas = 0;
`ifdef ECHO_JITTER_EN
        ref_lfsr = 16'hACE1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        p1 = pulses;
        repeat (5) @(negedge clk);
        check("rst no glitch", echo, 0);
        check("rst no pulse", pulses - p1, 0);
        run_trial(10, 7, 1'b1, 1'b1, 49, 1'b0, "after_rst");

        // Randomized trials against the width model.
        for (int i = 0; i < 15; i++) begin
            int w;
            int d;
            bit tv;
            w  = $urandom_range(7, 13);
            d  = $urandom_range(0, 60);
            tv = ($urandom_range(0, 3) != 0);
            run_trial(w, d, tv, (w >= P_MIN_TRIG), model_width(d, tv), 1'b1, "rand");
        end

`ifdef ECHO_JITTER_EN
        for (int i = 0; i < 8; i++)
            run_trial(10, 10, 1'b1, 1'b1, 70, 1'b0, "jitter");
        run_trial(10, 10, 1'b0, 1'b1, P_TIMEOUT, 1'b0, "jitter_timeout");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
